microwave_timer_ctrl: RTL and testbench

Cook-time sequencer for the microwave. It accepts keypad digits as MM:SS and runs a start/pause/stop state machine gated by the door switch. On each one-cycle tick from the DivideBy100 divider chain it counts the time down in BCD, and it drives the magnetron enable and the done indication. It sits between the keypad/door inputs, the divider tick and the display/magnetron outputs.

---
 rtl/microwave_pkg.sv | 12 +
 rtl/microwave_timer_ctrl_if.sv | 25 ++
 rtl/microwave_timer_ctrl_bcd_timer4.sv | 49 ++++
 rtl/microwave_timer_ctrl.sv | 102 ++++++++++
 tb/tb_microwave_timer_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: state encoding and BCD digit constants shared by the microwave timer.
package microwave_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// microwave_timer_ctrl_if: keypad/door/tick inputs and display/magnetron outputs of the timer.
interface microwave_timer_ctrl_if;
    import microwave_pkg::*;
    logic               tick;
    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               start;
    logic               stop;
    logic               door_closed;
    logic               mag_on;
    logic               done;
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [2:0]         state_o;
    modport master (
        output tick, key_valid, key_digit, start, stop, door_closed,
        input  mag_on, done, min_tens, min_ones, sec_tens, sec_ones, state_o
    );
    modport slave (
        input  tick, key_valid, key_digit, start, stop, door_closed,
        output mag_on, done, min_tens, min_ones, sec_tens, sec_ones, state_o
    );
endinterface

// File: rtl/microwave_timer_ctrl_bcd_timer4.sv
// bcd_timer4: four BCD digit registers (MM:SS) with key shift-in and borrow-chained decrement.
module bcd_timer4
    import microwave_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_shift_en,
    input  logic [DIGIT_W-1:0] i_shift_digit,
    input  logic               i_dec_en,
    output logic [DIGIT_W-1:0] o_min_tens,
    output logic [DIGIT_W-1:0] o_min_ones,
    output logic [DIGIT_W-1:0] o_sec_tens,
    output logic [DIGIT_W-1:0] o_sec_ones,
    output logic               o_is_zero,
    output logic               o_is_one
);
    logic [DIGIT_W-1:0] r_mt, r_mo, r_st, r_so;
    logic               w_so_b, w_st_b, w_mo_b;

    // each borrow ripples only when every lower digit is zero
    assign w_so_b = r_so == '0;
    assign w_st_b = w_so_b && r_st == '0;
    assign w_mo_b = w_st_b && r_mo == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_mt, r_mo, r_st, r_so} <= '0;
        end else if (i_clr) begin
            {r_mt, r_mo, r_st, r_so} <= '0;
        end else if (i_shift_en) begin
            {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, i_shift_digit};
        end else if (i_dec_en) begin
            r_so <= w_so_b ? BCD_MAX : r_so - 1'b1;
            r_st <= w_so_b ? (r_st == '0 ? SEC_TENS_WRAP : r_st - 1'b1) : r_st;
            r_mo <= w_st_b ? (r_mo == '0 ? BCD_MAX : r_mo - 1'b1) : r_mo;
            r_mt <= w_mo_b ? r_mt - 1'b1 : r_mt;
        end
    end

    assign o_min_tens = r_mt;
    assign o_min_ones = r_mo;
    assign o_sec_tens = r_st;
    assign o_sec_ones = r_so;
    assign o_is_zero  = {r_mt, r_mo, r_st, r_so} == '0;
    assign o_is_one   = {r_mt, r_mo, r_st, r_so} == 16'h0001;
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: start/pause/stop cook sequencer gated by the door, counting MM:SS down on each tick.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int                 DONE_TICKS    = 3,
    parameter logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5
) (
    input  logic                  clk,
    input  logic                  rst,
    microwave_timer_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DONE_TICKS + 1);

    state_t           r_state;
    logic             r_mag;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_next;
    logic             w_clr, w_shift, w_dec;
    logic             w_key, w_key_nz, w_can_cook, w_is_zero, w_is_one;

    assign w_key      = bus.key_valid && bus.key_digit <= BCD_MAX;
    assign w_key_nz   = {bus.min_ones, bus.sec_tens, bus.sec_ones, bus.key_digit} != '0;
    assign w_can_cook = bus.start && bus.door_closed && !w_is_zero;

    // priority: stop > door open > start > key > tick
    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_shift = 1'b0;
        w_dec   = 1'b0;
        case (r_state)
            IDLE, READY: begin
                if (bus.stop) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                end else if (r_state == READY && w_can_cook) begin
                    w_next = COOK;
                end else if (w_key) begin
                    w_shift = 1'b1;
                    w_next  = w_key_nz ? READY : IDLE;
                end
            end
            COOK: begin
                if (bus.stop || !bus.door_closed) begin
                    w_next = PAUSE;
                end else if (bus.tick) begin
                    w_dec  = 1'b1;
                    w_next = w_is_one ? DONE : COOK;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                end else if (w_can_cook) begin
                    w_next = COOK;
                end
            end
            DONE: begin
                if (bus.stop || bus.start || bus.key_valid)
                    w_next = IDLE;
                else if (bus.tick && r_cnt == CNT_W'(DONE_TICKS - 1))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mag   <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_mag   <= w_next == COOK;
            r_done  <= w_next == DONE;
            r_cnt   <= w_next != DONE ? '0 : (r_state == DONE && bus.tick) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    bcd_timer4 #(.SEC_TENS_WRAP(SEC_TENS_WRAP)) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_clr),
        .i_shift_en    (w_shift),
        .i_shift_digit (bus.key_digit),
        .i_dec_en      (w_dec),
        .o_min_tens    (bus.min_tens),
        .o_min_ones    (bus.min_ones),
        .o_sec_tens    (bus.sec_tens),
        .o_sec_ones    (bus.sec_ones),
        .o_is_zero     (w_is_zero),
        .o_is_one      (w_is_one)
    );

    assign bus.mag_on  = r_mag;
    assign bus.done    = r_done;
    assign bus.state_o = r_state;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: directed cook/pause/done/reset sequences with hand-computed expectations.
module tb_microwave_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    microwave_timer_ctrl_if bus();

    microwave_timer_ctrl #(.DONE_TICKS(3), .SEC_TENS_WRAP(4'd5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic press_stop();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
        end
        bus.tick = 1'b0;
    endtask

    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        bus.tick = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.door_closed = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_state", 16'(bus.state_o), 16'd0);
        chk("reset_digits", digits(), 16'h0000);
        chk("reset_mag", 16'(bus.mag_on), 16'd0);
        chk("reset_done", 16'(bus.done), 16'd0);

        key(4'd1);
        chk("key1_digits", digits(), 16'h0001);
        chk("key1_state", 16'(bus.state_o), 16'd1);
        key(4'd3);
        key(4'd0);
        chk("key130_digits", digits(), 16'h0130);
        press_start();
        chk("start_state", 16'(bus.state_o), 16'd2);
        chk("start_mag", 16'(bus.mag_on), 16'd1);
        tk(1);
        chk("tick1_digits", digits(), 16'h0129);
        tk(30);
        chk("min_borrow_digits", digits(), 16'h0059);
        chk("min_borrow_state", 16'(bus.state_o), 16'd2);
        press_stop();
        chk("stop_pause_state", 16'(bus.state_o), 16'd3);
        chk("stop_pause_mag", 16'(bus.mag_on), 16'd0);
        chk("stop_pause_digits", digits(), 16'h0059);
        press_stop();
        chk("stop_idle_state", 16'(bus.state_o), 16'd0);
        chk("stop_idle_digits", digits(), 16'h0000);

        key(4'd0);
        chk("zero_key_state", 16'(bus.state_o), 16'd0);
        key(4'd5);
        chk("key05_state", 16'(bus.state_o), 16'd1);
        press_start();
        tk(4);
        chk("cook4_digits", digits(), 16'h0001);
        chk("cook4_done", 16'(bus.done), 16'd0);
        tk(1);
        chk("done_digits", digits(), 16'h0000);
        chk("done_state", 16'(bus.state_o), 16'd4);
        chk("done_flag", 16'(bus.done), 16'd1);
        chk("done_mag", 16'(bus.mag_on), 16'd0);
        tk(2);
        chk("done_hold_state", 16'(bus.state_o), 16'd4);
        chk("done_hold_flag", 16'(bus.done), 16'd1);
        tk(1);
        chk("done_exit_state", 16'(bus.state_o), 16'd0);
        chk("done_exit_flag", 16'(bus.done), 16'd0);

        key(4'd0);
        key(4'd9);
        press_start();
        tk(2);
        chk("pre_door_digits", digits(), 16'h0007);
        bus.door_closed = 1'b0;
        cyc();
        chk("door_open_state", 16'(bus.state_o), 16'd3);
        chk("door_open_mag", 16'(bus.mag_on), 16'd0);
        tk(3);
        chk("pause_tick_digits", digits(), 16'h0007);
        chk("pause_tick_state", 16'(bus.state_o), 16'd3);
        bus.door_closed = 1'b1;
        press_start();
        chk("resume_state", 16'(bus.state_o), 16'd2);
        chk("resume_mag", 16'(bus.mag_on), 16'd1);
        tk(1);
        chk("resume_digits", digits(), 16'h0006);
        bus.stop = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.stop = 1'b0;
        bus.tick = 1'b0;
        chk("stop_tick_state", 16'(bus.state_o), 16'd3);
        chk("stop_tick_digits", digits(), 16'h0006);
        press_stop();
        chk("stop2_digits", digits(), 16'h0000);

        press_start();
        chk("zero_start_state", 16'(bus.state_o), 16'd0);
        chk("zero_start_mag", 16'(bus.mag_on), 16'd0);
        key(4'd1);
        key(4'd0);
        bus.door_closed = 1'b0;
        press_start();
        chk("open_start_state", 16'(bus.state_o), 16'd1);
        chk("open_start_mag", 16'(bus.mag_on), 16'd0);
        bus.door_closed = 1'b1;
        press_stop();
        key(4'd12);
        chk("bad_key_idle_digits", digits(), 16'h0000);
        chk("bad_key_idle_state", 16'(bus.state_o), 16'd0);
        key(4'd4);
        key(4'd12);
        chk("bad_key_ready_digits", digits(), 16'h0004);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        key(4'd5);
        chk("shift_out_digits", digits(), 16'h2345);

        press_stop();
        key(4'd4);
        key(4'd5);
        press_start();
        chk("pre_rst_mag", 16'(bus.mag_on), 16'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_mag", 16'(bus.mag_on), 16'd0);
        chk("async_rst_digits", digits(), 16'h0000);
        chk("async_rst_state", 16'(bus.state_o), 16'd0);
        cyc();
        rst = 1'b0;

        key(4'd2);
        press_start();
        tk(2);
        chk("done2_state", 16'(bus.state_o), 16'd4);
        key(4'd7);
        chk("done_key_state", 16'(bus.state_o), 16'd0);
        chk("done_key_flag", 16'(bus.done), 16'd0);
        chk("done_key_digits", digits(), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
